// File: rtl/sys_rst_seq.sv
// System reset sequencer: pulses the PLL reset, waits for a stable lock, holds the system in reset, then releases it.
// Optional build macro SYS_RST_SEQ_TIMEOUT_EN re-pulses the PLL if lock never arrives within LOCK_TIMEOUT_CYCLES.
module sys_rst_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RST_HOLD_CYCLES     = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked_i,
    input  logic       sw_rst_req_i,
    output logic       pll_rst_o,
    output logic       sys_rst_n_o,
    output logic [7:0] lock_lost_cnt_o,
    output logic [2:0] seq_state_o
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CD  = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    // The counter is loaded with N-1 and stops at zero, so it never needs to hold MAX_CYC itself.
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PLL_LOAD    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RST_HOLD_CYCLES - 1);
`ifdef SYS_RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`else
    localparam logic [CNT_W-1:0] WAIT_LOAD   = '0;
`endif

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_dec;
    logic             lock_meta, lock_s;
    logic             lost_inc;

    assign cnt_dec     = (cnt != '0) ? cnt - 1'b1 : cnt;
    assign seq_state_o = state;

    // NOTE: every output of this block is assigned a default before the case, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_dec;
        lost_inc  = 1'b0;
        case (state)
            S_PLL_RST: begin
                if (cnt == '0) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = WAIT_LOAD;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = S_STABLE;
                    cnt_nxt   = STABLE_LOAD;
                end
`ifdef SYS_RST_SEQ_TIMEOUT_EN
                else if (cnt == '0) begin
                    state_nxt = S_PLL_RST;
                    cnt_nxt   = PLL_LOAD;
                end
`endif
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = WAIT_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (!lock_s) begin
                    state_nxt = S_PLL_RST;
                    cnt_nxt   = PLL_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                // Lock loss is checked first so it wins over a coincident software request.
                if (!lock_s) begin
                    state_nxt = S_PLL_RST;
                    cnt_nxt   = PLL_LOAD;
                    lost_inc  = 1'b1;
                end else if (sw_rst_req_i) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            default: begin
                state_nxt = S_PLL_RST;
                cnt_nxt   = PLL_LOAD;
            end
        endcase
    end

    // NOTE: rst_n is sampled only on the clock edge (synchronous reset), and all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_meta       <= 1'b0;
            lock_s          <= 1'b0;
            state           <= S_PLL_RST;
            cnt             <= PLL_LOAD;
            pll_rst_o       <= 1'b1;
            sys_rst_n_o     <= 1'b0;
            lock_lost_cnt_o <= 8'd0;
        end else begin
            lock_meta   <= pll_locked_i;
            lock_s      <= lock_meta;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            // Outputs are decoded from the next state so they change on the same edge as the state itself.
            pll_rst_o   <= (state_nxt == S_PLL_RST);
            sys_rst_n_o <= (state_nxt == S_RUN);
            if (lost_inc && (lock_lost_cnt_o != 8'hFF)) begin
                lock_lost_cnt_o <= lock_lost_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sys_rst_seq.sv
// Scoreboard bench for sys_rst_seq: stimulus predicts output transitions by cycle number, a monitor checks them.
module tb_sys_rst_seq;

    localparam logic [2:0] ST_PLL = 3'd0, ST_WAIT = 3'd1, ST_STABLE = 3'd2, ST_HOLD = 3'd3, ST_RUN = 3'd4;
    localparam int LT = 64;
    localparam int PR = 4;

    logic       clk = 1'b0;
    logic       rst_n, pll_locked_i, sw_rst_req_i;
    logic       pll_rst_o, sys_rst_n_o;
    logic [7:0] lock_lost_cnt_o;
    logic [2:0] seq_state_o;

    sys_rst_seq #(
        .PLL_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(64), .LOCK_STABLE_CYCLES(16), .RST_HOLD_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked_i(pll_locked_i), .sw_rst_req_i(sw_rst_req_i),
        .pll_rst_o(pll_rst_o), .sys_rst_n_o(sys_rst_n_o),
        .lock_lost_cnt_o(lock_lost_cnt_o), .seq_state_o(seq_state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  st;
        logic        pll;
        logic        sysn;
        logic [7:0]  cnt;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  m_cnt    = 0;
    bit  mon_en   = 0;
    bit  primed   = 0;
    ev_t prev, cur, e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] s, input logic p, input logic n);
        ev_t x;
        x.cyc = 32'(c); x.st = s; x.pll = p; x.sysn = n; x.cnt = 8'(m_cnt);
        exp_q.push_back(x);
    endtask

    // Monitor: every change of the visible outputs must match the next predicted transition.
    always @(negedge clk) begin
        if (mon_en) begin
            cur.cyc = 32'(cyc); cur.st = seq_state_o; cur.pll = pll_rst_o;
            cur.sysn = sys_rst_n_o; cur.cnt = lock_lost_cnt_o;
            if (!primed) begin
                prev   = cur;
                primed = 1;
            end else if ({cur.st, cur.pll, cur.sysn, cur.cnt} !== {prev.st, prev.pll, prev.sysn, prev.cnt}) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL event: unexpected change at cycle %0d to st=%0d pll=%0b sysn=%0b cnt=%0d",
                             cyc, cur.st, cur.pll, cur.sysn, cur.cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e !== cur) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d st=%0d pll=%0b sysn=%0b cnt=%0d, expected cyc=%0d st=%0d pll=%0b sysn=%0b cnt=%0d",
                                 cur.cyc, cur.st, cur.pll, cur.sysn, cur.cnt, e.cyc, e.st, e.pll, e.sysn, e.cnt);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Raise lock while waiting for it; mode 0 clean, 1 one-cycle glitch at STABLE cycle p,
    // 2 one-cycle glitch during HOLD at offset p, 3 one-cycle rst_n pulse during HOLD at offset p.
    task automatic lock_up(input int mode, input int p);
        int k, j, end_t;
        k = cyc;
        j = k + p;
        pll_locked_i = 1'b1;
        push(k + 3, ST_STABLE, 0, 0);
        case (mode)
            0: begin
                push(k + 19, ST_HOLD, 0, 0); push(k + 27, ST_RUN, 0, 1); end_t = k + 27;
            end
            1: begin
                push(k + 3 + p, ST_WAIT, 0, 0); push(k + 4 + p, ST_STABLE, 0, 0);
                push(k + 20 + p, ST_HOLD, 0, 0); push(k + 28 + p, ST_RUN, 0, 1); end_t = k + 28 + p;
            end
            2: begin
                push(k + 19, ST_HOLD, 0, 0); push(j + 3, ST_PLL, 1, 0); push(j + 7, ST_WAIT, 0, 0);
                push(j + 8, ST_STABLE, 0, 0); push(j + 24, ST_HOLD, 0, 0); push(j + 32, ST_RUN, 0, 1);
                end_t = j + 32;
            end
            default: begin
                push(k + 19, ST_HOLD, 0, 0);
                m_cnt = 0;
                push(j + 1, ST_PLL, 1, 0); push(j + 5, ST_WAIT, 0, 0); push(j + 6, ST_STABLE, 0, 0);
                push(j + 22, ST_HOLD, 0, 0); push(j + 30, ST_RUN, 0, 1); end_t = j + 30;
            end
        endcase
        for (int t = k; t < end_t; t++) begin
            if (mode == 1 || mode == 2) begin
                if (t == j)     pll_locked_i = 1'b0;
                if (t == j + 1) pll_locked_i = 1'b1;
            end
            if (mode == 3) begin
                if (t == j) rst_n = 1'b0;
                if (t == j + 1) begin
                    rst_n = 1'b1;
                    check("hold_rst_state", seq_state_o, ST_PLL);
                    check("hold_rst_pll", pll_rst_o, 1);
                    check("hold_rst_sysn", sys_rst_n_o, 0);
                    check("hold_rst_cnt", lock_lost_cnt_o, 0);
                end
            end
            // Requests outside RUN must be ignored.
            sw_rst_req_i = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        sw_rst_req_i = 1'b0;
    endtask

    // Drop lock in RUN; co=1 also raises a software request on the cycle the loss is seen.
    task automatic run_drop(input bit co);
        int k;
        k = cyc;
        pll_locked_i = 1'b0;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        push(k + 3, ST_PLL, 1, 0);
        push(k + 7, ST_WAIT, 0, 0);
        for (int t = k; t < k + 7; t++) begin
            if (t == k + 2)      sw_rst_req_i = co;
            else if (t >= k + 4) sw_rst_req_i = ($urandom_range(0, 3) == 0);
            else                 sw_rst_req_i = 1'b0;
            @(negedge clk);
        end
        sw_rst_req_i = 1'b0;
    endtask

    task automatic sw_pulse();
        int k;
        k = cyc;
        sw_rst_req_i = 1'b1;
        push(k + 1, ST_HOLD, 0, 0);
        push(k + 9, ST_RUN, 0, 1);
        for (int t = k; t < k + 9; t++) begin
            if (t > k) sw_rst_req_i = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        sw_rst_req_i = 1'b0;
    endtask

    task automatic run_idle(input int n);
        sw_rst_req_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called on the cycle WAIT_LOCK is entered, with lock low.
    task automatic wait_in_wait(input int n);
        int w;
        w = cyc;
`ifdef SYS_RST_SEQ_TIMEOUT_EN
        for (int p = w + LT; p < w + n; p += LT + PR) begin
            push(p, ST_PLL, 1, 0);
            push(p + PR, ST_WAIT, 0, 0);
        end
`endif
        repeat (n) begin
            sw_rst_req_i = ($urandom_range(0, 4) == 0);
            @(negedge clk);
        end
        sw_rst_req_i = 1'b0;
    endtask

    initial begin
        int r;
        rst_n = 1'b0; pll_locked_i = 1'b0; sw_rst_req_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", seq_state_o, ST_PLL);
        check("reset_pll", pll_rst_o, 1);
        check("reset_sysn", sys_rst_n_o, 0);
        check("reset_cnt", lock_lost_cnt_o, 0);
        mon_en = 1;
        repeat (2) @(negedge clk);

        rst_n = 1'b1;
        r = cyc;
        push(r + 4, ST_WAIT, 0, 0);
        repeat (10) @(negedge clk);
        lock_up(0, 0);
        check("first_run_state", seq_state_o, ST_RUN);
        check("first_run_sysn", sys_rst_n_o, 1);

        run_idle(3);
        sw_pulse();
        check("sw_run_pll", pll_rst_o, 0);
        run_idle(2);
        run_drop(0);
        check("lost_cnt_1", lock_lost_cnt_o, 1);

        wait_in_wait(150);
        check("idle_wait_state", seq_state_o, ST_WAIT);
        lock_up(0, 0);
        run_idle(2);
        run_drop(1);
        check("coincident_cnt", lock_lost_cnt_o, 2);

        wait_in_wait($urandom_range(0, 5));
        lock_up(1, 10);
        run_drop(0);
        wait_in_wait($urandom_range(0, 5));
        lock_up(2, $urandom_range(17, 24));
        run_drop(0);
        wait_in_wait($urandom_range(0, 5));
        lock_up(3, $urandom_range(19, 25));

        for (int i = 0; i < 300; i++) begin
            run_idle($urandom_range(1, 4));
            if ($urandom_range(0, 2) == 0) begin
                sw_pulse();
                run_idle(1);
            end
            run_drop(1'($urandom_range(0, 1)));
            wait_in_wait($urandom_range(0, 5));
            lock_up($urandom_range(0, 1), $urandom_range(1, 15));
        end
        check("lost_cnt_sat", lock_lost_cnt_o, 255);

        run_idle(5);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
